// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register, one-shot I-cache request FSM and a small decode FIFO.
// A redirect flushes the FIFO and drops any cache response still in flight.
module instruction_fetch #(
    parameter int ADDRESS_BITWIDTH = 32,
    parameter int DATA_BITWIDTH = 32,
    parameter logic [ADDRESS_BITWIDTH-1:0] RESET_PC = '0,
    parameter int FIFO_DEPTH_BITWIDTH = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        redirect,
    input  logic [ADDRESS_BITWIDTH-1:0] redirect_pc,
    output logic                        instr_valid,
    output logic [DATA_BITWIDTH-1:0]    instr,
    output logic [ADDRESS_BITWIDTH-1:0] instr_pc,
    input  logic                        instr_ready,
    output logic                        ic_enable,
    output logic [ADDRESS_BITWIDTH-1:0] ic_address,
    input  logic [DATA_BITWIDTH-1:0]    ic_data,
    input  logic                        ic_data_ready,
    input  logic                        ic_busy
);
    localparam int AW = ADDRESS_BITWIDTH;
    localparam int DW = DATA_BITWIDTH;
    localparam int FB = FIFO_DEPTH_BITWIDTH;
    localparam int DEPTH = 1 << FB;

    typedef enum logic [1:0] {ISSUE, RESP, MISS_WAIT, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    pc_q, pc_d;
    logic             discard_q, discard_d;
    logic [FB-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [FB:0]      count_q, count_d;
    logic [DW+AW-1:0] mem_q [DEPTH];
    logic             capture, push, pop;

    // count never exceeds DEPTH, so its top bit alone means "full"
    assign ic_enable   = !rst && state_q == ISSUE && !count_q[FB] && !ic_busy && !redirect;
    assign ic_address  = pc_q;
    assign instr_valid = count_q != '0;
    assign {instr, instr_pc} = mem_q[rd_q];
    assign capture = (state_q == RESP && !ic_busy) || (state_q == MISS_WAIT && ic_data_ready);
    assign push    = capture && !discard_q && !redirect;
    assign pop     = instr_valid && instr_ready && !redirect;

    always_comb begin
        state_d = state_q == ISSUE     ? (ic_enable ? RESP : ISSUE) :
                  state_q == RESP      ? (ic_busy ? MISS_WAIT : ISSUE) :
                  state_q == MISS_WAIT ? (!ic_data_ready ? MISS_WAIT : ic_busy ? DRAIN : ISSUE) :
                                         (ic_busy ? DRAIN : ISSUE);
        discard_d = state_d != ISSUE && (redirect || discard_q);
        pc_d    = redirect ? (redirect_pc & ~AW'(3)) : push ? pc_q + AW'(4) : pc_q;
        wr_d    = redirect ? '0 : wr_q + FB'(push);
        rd_d    = redirect ? '0 : rd_q + FB'(pop);
        count_d = redirect ? '0 : count_q + (FB+1)'(push) - (FB+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ISSUE;
            pc_q      <= RESET_PC;
            discard_q <= 1'b0;
            rd_q      <= '0;
            wr_q      <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {ic_data, pc_q};
    end

    always_ff @(posedge clk) begin
        if (!rst && push) assert (!count_q[FB]);
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: behavioural I-cache drives the fetch stage; a scoreboard of
// expected {instr, pc} entries is filled at each response and drained on decode pops.
module tb_instruction_fetch;
    logic        clk = 1'b0;
    logic        rst, redirect, instr_ready, ic_data_ready, ic_busy;
    logic [31:0] redirect_pc, ic_data;
    logic        instr_valid, ic_enable;
    logic [31:0] instr, instr_pc, ic_address;

    instruction_fetch dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
        .ic_enable(ic_enable), .ic_address(ic_address), .ic_data(ic_data),
        .ic_data_ready(ic_data_ready), .ic_busy(ic_busy)
    );

    always #5 clk = ~clk;

    int          checks = 0, failures = 0, n_iss = 0, n_pop = 0, busy_idx = 0;
    logic [63:0] exp_q[$];
    logic [31:0] exp_pc = '0, req_addr = '0, miss_addr = '0, miss_data = '0;
    logic        prev_en = 1'b0, resp_hit = 1'b0, disc_m = 1'b0, miss_armed = 1'b0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
    endfunction

    // One clock: sample mid-cycle, then update the cache model just after the edge.
    task automatic tick();
        logic        en_s, rst_s, cap;
        logic [31:0] addr_s;
        logic [63:0] e;
        #4;
        en_s = ic_enable;
        addr_s = ic_address;
        rst_s = rst;
        if (en_s) begin
            n_iss++;
            checks++;
            if (addr_s !== exp_pc) begin
                failures++;
                $display("FAIL issue_addr: got %h expected %h", addr_s, exp_pc);
            end
            checks++;
            if (prev_en || busy_idx != 0) begin
                failures++;
                $display("FAIL issue_timing: back_to_back=%0b busy_cycle=%0d expected 0 and 0", prev_en, busy_idx);
            end
        end
        prev_en = en_s;
        if (instr_valid && instr_ready && !redirect && !rst_s) begin
            n_pop++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected: got %h@%h expected no entry", instr, instr_pc);
            end else begin
                e = exp_q.pop_front();
                if ({instr, instr_pc} !== e) begin
                    failures++;
                    $display("FAIL pop_data: got %h@%h expected %h@%h", instr, instr_pc, e[63:32], e[31:0]);
                end
            end
        end
        cap = resp_hit || busy_idx == 3;
        if (cap && !redirect && !disc_m && !rst_s) begin
            exp_q.push_back({resp_hit ? mem(req_addr) : miss_data, req_addr});
            exp_pc += 4;
        end
        if (cap) disc_m = 1'b0;
        if (redirect) begin
            exp_q.delete();
            exp_pc = redirect_pc & ~32'h3;
            if (busy_idx == 1 || busy_idx == 2) disc_m = 1'b1;
        end
        @(posedge clk);
        #1;
        resp_hit = 1'b0;
        if (rst_s) begin
            busy_idx = 0;
            ic_busy = 1'b0;
            ic_data_ready = 1'b0;
        end else if (en_s) begin
            req_addr = addr_s;
            if (miss_armed && addr_s == miss_addr) begin
                miss_armed = 1'b0;
                busy_idx = 1;
                ic_busy = 1'b1;
            end else begin
                resp_hit = 1'b1;
                ic_data_ready = 1'b1;
                ic_data = mem(addr_s);
            end
        end else if (busy_idx > 0) begin
            busy_idx++;
            if (busy_idx == 2) ic_data_ready = 1'b0;
            if (busy_idx == 3) begin
                ic_data_ready = 1'b1;
                ic_data = miss_data;
            end
            if (busy_idx == 7) begin
                busy_idx = 0;
                ic_busy = 1'b0;
            end
        end
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect = 1'b1;
        redirect_pc = target;
        tick();
        redirect = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (ic_enable !== 1'b0) begin
            failures++;
            $display("FAIL reset_enable: got %b expected 0", ic_enable);
        end
        checks++;
        if (instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid: got %b expected 0", instr_valid);
        end
        rst = 1'b0;
        exp_q.delete();
        exp_pc = 32'h0;
        checks++;
        if (ic_address !== 32'h0) begin
            failures++;
            $display("FAIL reset_pc: got %h expected 00000000", ic_address);
        end
    endtask

    task automatic test_hits();
        int n0 = n_iss;
        repeat (6) tick();
        checks++;
        if (n_iss - n0 != 3) begin
            failures++;
            $display("FAIL hit_rate: got %0d issues in 6 cycles expected 3", n_iss - n0);
        end
    endtask

    task automatic test_miss();
        int n0;
        do_redirect(32'h20);
        miss_armed = 1'b1;
        miss_addr = 32'h20;
        miss_data = 32'h00500093;
        n0 = n_iss;
        repeat (9) tick();
        checks++;
        if (n_iss - n0 != 2) begin
            failures++;
            $display("FAIL miss_issues: got %0d issues expected 2", n_iss - n0);
        end
    endtask

    task automatic test_stall();
        int n0, p0;
        do_redirect(32'h300);
        instr_ready = 1'b0;
        n0 = n_iss;
        repeat (12) tick();
        checks++;
        if (n_iss - n0 != 2) begin
            failures++;
            $display("FAIL stall_issues: got %0d expected 2", n_iss - n0);
        end
        checks++;
        if (instr_valid !== 1'b1 || exp_q.size() != 2) begin
            failures++;
            $display("FAIL stall_fill: got valid=%b queued=%0d expected 1 and 2", instr_valid, exp_q.size());
        end
        instr_ready = 1'b1;
        p0 = n_pop;
        repeat (8) tick();
        checks++;
        if (n_pop - p0 < 3) begin
            failures++;
            $display("FAIL stall_resume: got %0d pops expected at least 3", n_pop - p0);
        end
    endtask

    task automatic test_redirect_capture_pop();
        instr_ready = 1'b0;
        for (int i = 0; i < 10 && !(resp_hit && instr_valid); i++) tick();
        checks++;
        if (!(resp_hit && instr_valid)) begin
            failures++;
            $display("FAIL rcp_setup: got hit=%b valid=%b expected 1 and 1", resp_hit, instr_valid);
        end
        instr_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h203;
        #1;
        checks++;
        if (ic_enable !== 1'b0) begin
            failures++;
            $display("FAIL rcp_enable: got %b expected 0", ic_enable);
        end
        tick();
        redirect = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || ic_address !== 32'h200) begin
            failures++;
            $display("FAIL rcp_flush: got valid=%b pc=%h expected 0 and 00000200", instr_valid, ic_address);
        end
        repeat (6) tick();
    endtask

    task automatic test_redirect_miss();
        int n0;
        do_redirect(32'h40);
        miss_armed = 1'b1;
        miss_addr = 32'h40;
        miss_data = 32'hDEADBEEF;
        for (int i = 0; i < 10 && busy_idx != 2; i++) tick();
        checks++;
        if (busy_idx != 2) begin
            failures++;
            $display("FAIL rm_setup: got busy cycle %0d expected 2", busy_idx);
        end
        do_redirect(32'h103);
        checks++;
        if (instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL rm_flush: got valid=%b expected 0", instr_valid);
        end
        n0 = n_iss;
        repeat (10) tick();
        checks++;
        if (n_iss - n0 < 1) begin
            failures++;
            $display("FAIL rm_resume: got %0d issues expected at least 1", n_iss - n0);
        end
    endtask

    task automatic test_wrap();
        int n0, p0;
        do_redirect(32'hFFFFFFFC);
        n0 = n_iss;
        p0 = n_pop;
        repeat (6) tick();
        checks++;
        if (n_iss - n0 < 2 || n_pop - p0 < 1) begin
            failures++;
            $display("FAIL wrap_progress: got issues=%0d pops=%0d expected >=2 and >=1", n_iss - n0, n_pop - p0);
        end
    endtask

    initial begin
        rst = 1'b1;
        redirect = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b1;
        ic_data_ready = 1'b0;
        ic_busy = 1'b0;
        ic_data = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_hits();
        test_miss();
        test_stall();
        test_redirect_capture_pop();
        test_redirect_miss();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
